// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
// Rotate support is selected at build time with SHIFTER_ROTATE_EN.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  function automatic int calc_lvl(input int bitwidth);
    return $clog2(bitwidth);
  endfunction

  function automatic int calc_nstage(input int lvl, input int levels_per_stage);
    return (lvl + levels_per_stage - 1) / levels_per_stage;
  endfunction

  localparam int DEF_BITWIDTH = 32;
  localparam int DEF_TAG_W    = 5;
  localparam int DEF_LPS      = 2;
  localparam int DEF_LVL      = calc_lvl(DEF_BITWIDTH);
  localparam int DEF_NSTAGE   = calc_nstage(DEF_LVL, DEF_LPS);

  // Payload for the default configuration; parametrised builds define a matching layout.
  typedef struct packed {
    logic [DEF_BITWIDTH-1:0] data;
    shift_op_e               op;
    logic [DEF_LVL-1:0]      shamt;
    logic                    sign;
    logic [DEF_TAG_W-1:0]    tag;
  } stage_payload_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Request/result bus of the pipelined barrel shifter, including the flush control.
interface pipelined_barrel_shifter_if #(
  parameter int BITWIDTH = 32,
  parameter int TAG_W    = 5
);
  import shifter_pkg::*;

  localparam int LVL = calc_lvl(BITWIDTH);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic [1:0]          in_op;
  logic [LVL-1:0]      in_shamt;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output flush, in_valid, in_data, in_op, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_data, in_op, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// Combinational slice applying mux levels FIRST_LVL .. FIRST_LVL+NUM_LVL-1 to a payload.
// ROR is only built when SHIFTER_ROTATE_EN is defined; otherwise op 11 behaves as SRL.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int  BITWIDTH  = 32,
  parameter int  FIRST_LVL = 0,
  parameter int  NUM_LVL   = 1,
  parameter type payload_t = stage_payload_t
) (
  input  payload_t stage_in,
  output payload_t stage_out
);

  logic [BITWIDTH-1:0] data_lvl;

  // SRA fills from the sign captured at entry, not from the partial result.
  function automatic logic [BITWIDTH-1:0] shift_level(
    input logic [BITWIDTH-1:0] d,
    input shift_op_e           op,
    input logic                sign,
    input int                  amt
  );
    logic [BITWIDTH-1:0] fill;
    fill = ~({BITWIDTH{1'b1}} >> amt);
    case (op)
      OP_SLL:  return d << amt;
      OP_SRA:  return (d >> amt) | (sign ? fill : '0);
`ifdef SHIFTER_ROTATE_EN
      OP_ROR:  return (d >> amt) | (d << (BITWIDTH - amt));
`endif
      default: return d >> amt;
    endcase
  endfunction

  always_comb begin
    stage_out = stage_in;
    data_lvl  = stage_in.data;
    for (int j = 0; j < NUM_LVL; j++) begin
      if (stage_in.shamt[FIRST_LVL + j]) begin
        data_lvl = shift_level(data_lvl, stage_in.op, stage_in.sign, 1 << (FIRST_LVL + j));
      end
    end
    stage_out.data = data_lvl;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA(/ROR) barrel shifter with valid/ready, global stall and tag sideband.
// Build option: SHIFTER_ROTATE_EN enables ROR for op 11 (otherwise decoded as SRL).
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int BITWIDTH         = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 5
) (
  input logic                        clk,
  input logic                        rst,
  pipelined_barrel_shifter_if.slave  bus
);

  localparam int LVL    = calc_lvl(BITWIDTH);
  localparam int NSTAGE = calc_nstage(LVL, LEVELS_PER_STAGE);

  typedef struct packed {
    logic [BITWIDTH-1:0] data;
    shift_op_e           op;
    logic [LVL-1:0]      shamt;
    logic                sign;
    logic [TAG_W-1:0]    tag;
  } payload_t;

  payload_t          entry;
  payload_t          stage_in  [NSTAGE];
  payload_t          stage_out [NSTAGE];
  payload_t          payload_p [NSTAGE];
  logic [NSTAGE-1:0] vld_p;
  logic              stall;

  assign stall         = vld_p[NSTAGE-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_p[NSTAGE-1];
  assign bus.out_data  = payload_p[NSTAGE-1].data;
  assign bus.out_tag   = payload_p[NSTAGE-1].tag;

  always_comb begin
    entry.data  = bus.in_data;
    entry.op    = shift_op_e'(bus.in_op);
    entry.shamt = bus.in_shamt;
    entry.sign  = bus.in_data[BITWIDTH-1];
    entry.tag   = bus.in_tag;
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int FL = k * LEVELS_PER_STAGE;
    localparam int NL = (FL + LEVELS_PER_STAGE > LVL) ? (LVL - FL) : LEVELS_PER_STAGE;

    if (k == 0) begin : g_first
      assign stage_in[k] = entry;
    end else begin : g_next
      assign stage_in[k] = payload_p[k-1];
    end

    shifter_stage #(
      .BITWIDTH  (BITWIDTH),
      .FIRST_LVL (FL),
      .NUM_LVL   (NL),
      .payload_t (payload_t)
    ) u_stage (
      .stage_in  (stage_in[k]),
      .stage_out (stage_out[k])
    );
  end

  // Stage boundaries: valid bits advance together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld_p <= '0;
    end else if (!stall) begin
      vld_p[0] <= bus.in_valid;
      for (int k = 1; k < NSTAGE; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // Only the output stage payload is cleared so out_data/out_tag read zero after reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTAGE - 1; k++) begin
      if (!stall) begin
        payload_p[k] <= stage_out[k];
      end
    end
    if (rst) begin
      payload_p[NSTAGE-1] <= '0;
    end else if (!stall) begin
      payload_p[NSTAGE-1] <= stage_out[NSTAGE-1];
    end
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the combinational barrel shifter, for the EXU shift path and the multi-cycle ALU.
- Performs SLL/SRL/SRA (and rotate when enabled) over log2(BITWIDTH) mux levels, with pipeline registers every LEVELS_PER_STAGE levels.
- Valid/ready handshake on input and output with full backpressure.
- Carries a sideband tag so the issuing unit can match results to requests.

Parameters:
- BITWIDTH, 32: data width; power of two, ≥ 8.
- LEVELS_PER_STAGE, 2: mux levels per pipeline stage; 1..log2(BITWIDTH).
- TAG_W, 5: sideband tag width (e.g. rd index).
- Derived: LVL = log2(BITWIDTH); NSTAGE = ceil(LVL / LEVELS_PER_STAGE); with defaults, LVL = 5 and NSTAGE = 3.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: synchronous reset, active-high.
- flush, in, 1: synchronous kill of all in-flight ops.
- in_valid, in, 1: request valid.
- in_ready, out, 1: block can accept a request this cycle.
- in_data, in, BITWIDTH: operand.
- in_op, in, 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_shamt, in, LVL: shift amount; upper bits beyond LVL are the caller's responsibility.
- in_tag, in, TAG_W: sideband tag, passed through unchanged.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, BITWIDTH: shifted result.
- out_tag, out, TAG_W: tag of the result.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all stage valid bits = 0; out_valid = 0; out_data = 0; out_tag = 0. in_ready = 1 in the cycle after reset deasserts.
- Level mapping:
  - Level i shifts by 2^i when shamt[i] = 1.
  - Levels are processed from i = 0 upward.
  - Stage k holds levels k·LEVELS_PER_STAGE .. min((k+1)·LEVELS_PER_STAGE, LVL) − 1.
- Per-stage registers: partial data, op, the remaining shamt bits, sign bit (in_data[MSB] captured at entry), tag, valid.
- Fill rules:
  - SLL: zero fill at LSB.
  - SRL: zero fill at MSB.
  - SRA: the fill is the captured original sign bit, never the partial result's MSB.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Latency: exactly NSTAGE cycles from accept (in_valid & in_ready) to out_valid, with no stall. Throughput is 1 op/cycle.
- Backpressure: global stall, stall = out_valid & ~out_ready.
  - While stalled, every stage holds its contents.
  - in_ready = ~stall.
  - No bubble-collapsing; a pipeline with bubbles still stalls as a whole.
- Output hold: out_data and out_tag stay stable while out_valid = 1 and out_ready = 0.
- shamt = 0: out_data = in_data for every op.
- Maximum shift (shamt = BITWIDTH−1):
  - SLL → {in_data[0], zeros}.
  - SRA → all sign bits except LSB = MSB... i.e. every bit equals the sign bit.
- flush:
  - Clears all valid bits next edge, including out_valid, regardless of stall.
  - The input handshake in the same cycle is dropped.
  - flush and rst have identical effect on valids; data regs are don't-care after flush.
- Simultaneous accept and output handshake in the same cycle: legal, pipeline advances.
- rst mid-operation: all in-flight ops are lost; no output is produced for them.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: in_op = 11 performs ROR as above.
- Undefined: rotate logic is not built; in_op = 11 is decoded as SRL and the fill is 0. Area saving only; the handshake is unchanged.

Decomposition:
- Package shifter_pkg holds:
  - enum shift_op_e (SLL, SRL, SRA, ROR).
  - Function clog2-based constants LVL and NSTAGE.
  - A struct for the stage payload {data, op, shamt, sign, tag}.
- Sub-module shifter_stage: combinational, parametrised by FIRST_LVL and NUM_LVL. It applies its levels to a payload. The top instantiates NSTAGE copies with registers between them.

Test Plan:
- SRA with BITWIDTH = 32: in_data = 0x80000000, in_shamt = 4 → out_data = 0xF8000000 exactly 3 cycles after accept, tag echoed.
- Back-to-back throughput: SLL of 0x00000001 with shamt 0..31 issued every cycle, out_ready = 1 → 32 consecutive results 1 << n, in order, no gaps.
- Backpressure: out_ready held 0 for 5 cycles with 3 ops in flight → in_ready = 0 and out_data stable. Release → 3 results in order with no loss and no duplication.
- ROR (SHIFTER_ROTATE_EN defined): 0x0000000F with shamt 4 → 0xF0000000. Same stimulus with the macro undefined → 0x00000000.
- flush with 2 ops in flight and out_valid = 1 → out_valid = 0 next cycle, and no stale results appear later.
- rst asserted mid-stream → next cycle out_valid = 0 and out_data = 0. After release, in_ready = 1 and a fresh SRL 0xFFFFFFFF by 31 → 0x00000001.
